// File: rtl/attn_pkg.sv
// Shared constants for the attention score engine, plus elaboration-time
// generation of the exp() lookup table used by the score stage.
package attn_pkg;

    localparam int VEC_LEN     = 4;
    localparam int FIFO_DEPTH  = 2;
    localparam int DATA_W      = 8;
    localparam int ACC_W       = 17;
    localparam int EXP_W       = 9;
    localparam int SCORE_SHIFT = 10;
    localparam int EX_ENTRIES  = 2 ** (DATA_W - 1);

    typedef logic [EX_ENTRIES-1:0][EXP_W-1:0] ex_tbl_t;

    // Entry i holds round-half-up(256 * exp(-(i+1)/16)).
    // exp(-1/16) comes from a Q60 Taylor series, then is raised by repeated
    // Q31 multiplication; the accumulated error stays far below 1/2 LSB.
    function automatic ex_tbl_t ex_table_gen();
        longint  term;
        longint  c60;
        longint  c31;
        longint  v;
        ex_tbl_t t;
        term = 64'sd1 <<< 60;
        c60  = term;
        for (int k = 1; k <= 14; k++) begin
            term = -term / (16 * k);
            c60  = c60 + term;
        end
        c31 = (c60 + (64'sd1 <<< 28)) >>> 29;
        v   = 64'sd1 <<< 31;
        for (int n = 0; n < EX_ENTRIES; n++) begin
            v    = (v * c31 + (64'sd1 <<< 30)) >>> 31;
            t[n] = EXP_W'((v + (64'sd1 <<< 22)) >>> 23);
        end
        return t;
    endfunction

endpackage

// File: rtl/attn_exp.sv
// Combinational exp() stage: signed Q3.4 score in, unsigned Q1.8 weight out.
// Non-negative scores saturate to 1.0; negative ones come from the table.
module attn_exp
    import attn_pkg::*;
(
    input  logic [DATA_W-1:0] mac_result_i,
    output logic [EXP_W-1:0]  ex_result_o
);

    localparam ex_tbl_t EX_TBL = ex_table_gen();

    // For negative x, ~x[6:0] == -x - 1, i.e. the table index directly.
    logic [DATA_W-2:0] idx;
    assign idx = ~mac_result_i[DATA_W-2:0];

    assign ex_result_o = mac_result_i[DATA_W-1] ? EX_TBL[idx] : EXP_W'(256);

endmodule

// File: rtl/attention_engine.sv
// Byte-serial attention score engine: stores a query, MACs streamed keys,
// exp()-scales each score and queues it in a credit-protected output FIFO.
module attention_engine
    import attn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int IW = $clog2(VEC_LEN);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [VEC_LEN-1:0][DATA_W-1:0]   q_q, q_d;
    logic [IW-1:0]                    qidx_q, qidx_d, kidx_q, kidx_d;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic [DATA_W-1:0]                mac_q, mac_d;
    logic                             v1_q, v1_d, qld_q, qld_d;
    logic [CW-1:0]                    credit_q, credit_d, cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][EXP_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                    rd_q, rd_d, wr_q, wr_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, acc_base, acc_sum;
    logic [EXP_W-1:0]           ex_val, head;
    logic in_valid, mode, out_ready, in_ready, out_valid;
    logic accept, reserve, push, pop, k_last;
    logic unused_uio;

    assign in_valid   = uio_in[0];
    assign mode       = uio_in[1];
    assign out_ready  = uio_in[2];
    assign unused_uio = &{1'b0, uio_in[7:3]};

    assign k_last    = (kidx_q == IW'(VEC_LEN - 1));
    assign out_valid = (cnt_q != '0);
    assign in_ready  = mode ? ((kidx_q != '0) || (credit_q != '0)) : (kidx_q == '0);
    assign accept    = ena & in_valid & in_ready;
    // A credit is taken when a key starts, so its result always has a FIFO slot.
    assign reserve   = accept & mode & (kidx_q == '0);
    assign push      = ena & v1_q;
    assign pop       = ena & out_valid & out_ready;

    assign prod     = $signed(q_q[kidx_q]) * $signed(ui_in);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_base = (kidx_q == '0) ? '0 : acc_q;
    assign acc_sum  = acc_base + prod_ext;

    attn_exp u_exp (
        .mac_result_i (mac_q),
        .ex_result_o  (ex_val)
    );

    assign head    = out_valid ? mem_q[rd_q] : '0;
    assign uo_out  = head[7:0];
    assign uio_out = {qld_q, in_ready, out_valid, head[8], 4'b0000};
    assign uio_oe  = 8'hF0;

    always_comb begin
        q_d      = q_q;
        qidx_d   = qidx_q;
        kidx_d   = kidx_q;
        acc_d    = acc_q;
        mac_d    = mac_q;
        v1_d     = v1_q;
        qld_d    = qld_q;
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        credit_d = credit_q + CW'(pop) - CW'(reserve);

        if (push) begin
            mem_d[wr_q] = ex_val;
            wr_d        = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            v1_d        = 1'b0;
        end
        if (pop)
            rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;

        if (accept && !mode) begin
            q_d[qidx_q] = ui_in;
            qidx_d      = (qidx_q == IW'(VEC_LEN - 1)) ? '0 : qidx_q + 1'b1;
            if (qidx_q == IW'(VEC_LEN - 1))
                qld_d = 1'b1;
        end
        if (accept && mode) begin
            acc_d  = acc_sum;
            kidx_d = k_last ? '0 : kidx_q + 1'b1;
            if (k_last) begin
                mac_d = DATA_W'(acc_sum >>> SCORE_SHIFT);
                v1_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            qidx_q   <= '0;
            kidx_q   <= '0;
            acc_q    <= '0;
            mac_q    <= '0;
            v1_q     <= 1'b0;
            qld_q    <= 1'b0;
            mem_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            credit_q <= CW'(FIFO_DEPTH);
        end else begin
            q_q      <= q_d;
            qidx_q   <= qidx_d;
            kidx_q   <= kidx_d;
            acc_q    <= acc_d;
            mac_q    <= mac_d;
            v1_q     <= v1_d;
            qld_q    <= qld_d;
            mem_q    <= mem_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: tb/tb_attention_engine.sv
// Directed bench for attention_engine: exp table sweep, score latency/values,
// credit back-pressure, enable gating and mid-operation reset.
module tb_attention_engine;
    import attn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic       vld = 1'b0, mode = 1'b0, ordy = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] ex_in = '0;
    logic [8:0] ex_out;
    int n_cmp = 0;
    int n_err = 0;

    assign uio_in = {5'b00000, ordy, mode, vld};

    always #5 clk = ~clk;

    attention_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    attn_exp u_exp (
        .mac_result_i (ex_in),
        .ex_result_o  (ex_out)
    );

    task automatic chk(input string tag, input int got, input int exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    function automatic int res();
        return int'({uio_out[4], uo_out});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic elem(input logic m, input int d);
        int t = 0;
        mode  = m;
        ui_in = 8'(d);
        vld   = 1'b1;
        #1;
        while (!uio_out[6] && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) chk("in_ready_timeout", 0, 1);
        tick();
        vld = 1'b0;
    endtask

    task automatic load_q(input int a, input int b, input int c, input int d);
        elem(1'b0, a); elem(1'b0, b); elem(1'b0, c); elem(1'b0, d);
    endtask

    task automatic send_key(input int a, input int b, input int c, input int d);
        elem(1'b1, a); elem(1'b1, b); elem(1'b1, c); elem(1'b1, d);
    endtask

    task automatic pop1();
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
    endtask

    // Sends one key into an empty FIFO, checks the one-edge latency and value, pops it.
    task automatic key_check(input int a, input int b, input int c, input int d,
                             input int expv, input string tag);
        send_key(a, b, c, d);
        chk({tag, "_lat_k"}, int'(uio_out[5]), 0);
        tick();
        chk({tag, "_lat_k1"}, int'(uio_out[5]), 1);
        chk(tag, res(), expv);
        pop1();
        chk({tag, "_empty"}, int'(uio_out[5]), 0);
    endtask

    initial begin
        int model;
        int spot_x [9] = '{0, 5, 127, -1, -8, -16, -32, -128, -64};
        int spot_e [9] = '{256, 256, 256, 240, 155, 94, 35, 0, 5};

        #12;
        chk("rst_uo_out", int'(uo_out), 0);
        chk("rst_uio_out", int'(uio_out), 8'h40);
        chk("rst_uio_oe", int'(uio_oe), 8'hF0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_uio_out", int'(uio_out), 8'h40);
        chk("idle_uo_out", int'(uo_out), 0);

        for (int x = -128; x < 128; x++) begin
            ex_in = 8'(x);
            #1;
            model = (x >= 0) ? 256 : int'($floor(256.0 * $exp(real'(x) / 16.0) + 0.5));
            chk("exp_sweep", int'(ex_out), model);
        end
        for (int i = 0; i < 9; i++) begin
            ex_in = 8'(spot_x[i]);
            #1;
            chk("exp_spot", int'(ex_out), spot_e[i]);
        end

        load_q(64, 64, 64, 64);
        chk("query_loaded", int'(uio_out[7]), 1);
        key_check(-64, -64, -64, -64, 94, "score_m16");
        load_q(127, 127, 127, 127);
        key_check(-128, -128, -128, -128, 5, "score_m64");
        load_q(64, 0, 0, 0);
        key_check(64, 0, 0, 0, 256, "score_p4");

        // Back-pressure: two credits, third key must stall until a pop.
        send_key(-64, 0, 0, 0);
        send_key(-128, 0, 0, 0);
        chk("bp_in_ready_low", int'(uio_out[6]), 0);
        tick(); tick();
        chk("bp_still_low", int'(uio_out[6]), 0);
        chk("bp_head1", res(), 199);
        pop1();
        chk("bp_ready_after_pop", int'(uio_out[6]), 1);
        chk("bp_head2", res(), 155);
        send_key(127, 0, 0, 0);
        tick();
        chk("bp_order", res(), 155);
        pop1();
        chk("bp_head3", res(), 256);
        pop1();
        chk("bp_empty", int'(uio_out[5]), 0);

        // ena low mid-key: offered element and pop request must be ignored.
        load_q(64, 64, 64, 64);
        elem(1'b1, -64); elem(1'b1, -64);
        ena = 1'b0; mode = 1'b1; ui_in = 8'd127; vld = 1'b1; ordy = 1'b1;
        repeat (3) tick();
        chk("ena_hold_uio", int'(uio_out), 8'hC0);
        vld = 1'b0; ordy = 1'b0; ena = 1'b1;
        elem(1'b1, -64); elem(1'b1, -64);
        tick();
        chk("ena_result", res(), 94);
        ena = 1'b0; ordy = 1'b1;
        repeat (2) tick();
        chk("ena_no_pop", int'(uio_out[5]), 1);
        ordy = 1'b0; ena = 1'b1;
        pop1();
        chk("ena_popped", int'(uio_out[5]), 0);

        // Reset mid-operation with a queued result and a partial key.
        send_key(-64, -64, -64, -64);
        tick();
        elem(1'b1, 5); elem(1'b1, 5);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_uio", int'(uio_out), 8'h40);
        chk("rst_mid_uo", int'(uo_out), 0);
        rst_n = 1'b1;
        send_key(1, 2, 3, 4);
        send_key(5, 6, 7, 8);
        chk("rst_credits_used", int'(uio_out[6]), 0);
        chk("rst_qloaded", int'(uio_out[7]), 0);
        tick();
        chk("rst_zero_q_1", res(), 256);
        pop1();
        chk("rst_zero_q_2", res(), 256);
        pop1();
        chk("rst_final_empty", int'(uio_out[5]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
